// File: rtl/divu_hilo.sv
// divu_hilo: multi-cycle restoring unsigned divider, quotient -> LO, remainder -> HI; define HILO_MT_EN to add mthi/mtlo writes
module divu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef HILO_MT_EN
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] mt_data,
`endif
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q, rem, dvs, rem_n, q_n, mt_val;
    logic [WIDTH:0]   rem_sh, diff;
    logic             ge, ready, mt_hi, mt_lo;
`ifdef HILO_MT_EN
    assign mt_hi  = mthi;
    assign mt_lo  = mtlo;
    assign mt_val = mt_data;
`else
    assign mt_hi  = 1'b0;
    assign mt_lo  = 1'b0;
    assign mt_val = '0;
`endif
    assign busy  = (state == RUN);
    assign ready = (state != RUN);
    // One restoring step: shift in the next dividend bit, subtract the divisor when it fits
    always_comb begin
        rem_sh = {rem, q[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvs};
        ge     = rem_sh >= {1'b0, dvs};
        rem_n  = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        q_n    = {q[WIDTH-2:0], ge};
    end
    // Control FSM, iteration datapath and HI/LO registers; MT writes land last so they win in FIN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            q           <= '0;
            rem         <= '0;
            dvs         <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            HiOut       <= '0;
            LoOut       <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            if (state == RUN) begin
                q   <= q_n;
                rem <= rem_n;
                cnt <= cnt + 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    state <= FIN;
                    done  <= 1'b1;
                    HiOut <= rem_n;
                    LoOut <= q_n;
                end
            end else if (start) begin
                cnt <= '0;
                q   <= dividend;
                rem <= '0;
                dvs <= divisor;
                if (divisor == '0) begin
                    state       <= FIN;
                    done        <= 1'b1;
                    div_by_zero <= 1'b1;
                    HiOut       <= dividend;
                    LoOut       <= '1;
                end else begin
                    state <= RUN;
                end
            end else begin
                state <= IDLE;
            end
            if (ready && mt_hi) HiOut <= mt_val;
            if (ready && mt_lo) LoOut <= mt_val;
        end
    end
endmodule
